multicycle_control: RTL and testbench

Multi-cycle control unit for the RISC core: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the 2-bit ALU operation select plus all datapath strobes. It is the producer of the ALU's operation code, sitting between the instruction register/memories and the datapath. It handles instruction-fetch and data-memory wait handshakes with a bounded timeout.

---
 rtl/multicycle_control.sv | 153 +++++++++++++++
 tb/tb_multicycle_control.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives the ALU op select, datapath strobes and memory handshakes.
module multicycle_control #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        imem_valid,
   input  logic        zero,
   input  logic        dmem_ready,
   output logic [1:0]  alu_op,
   output logic        alu_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic        wb_sel,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        halted,
   output logic        illegal,
   output logic        mem_timeout
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'h6;
   localparam logic [3:0] OP_J    = 4'h7;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [3:0] opcode;
   logic [7:0] wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         opcode      <= 4'h0;
         wait_cnt    <= 8'h00;
         illegal     <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_valid) begin
                  opcode <= instr[31:28];
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_ADDI,
                  OP_LW, OP_SW, OP_BEQ:          state <= S_EXEC;
                  OP_J:                          state <= S_FETCH;
                  OP_HLT:                        state <= S_HALT;
                  default: begin
                     state   <= S_HALT;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_EXEC: begin
               wait_cnt <= 8'h00;
               case (opcode)
                  OP_LW, OP_SW: state <= S_MEM;
                  OP_BEQ:       state <= S_FETCH;
                  default:      state <= S_WB;
               endcase
            end
            S_MEM: begin
               // Completion has priority over the timeout in the same cycle.
               if (dmem_ready) begin
                  state <= (opcode == OP_LW) ? S_WB : S_FETCH;
               end else if (wait_cnt == WAIT_LAST) begin
                  state       <= S_HALT;
                  mem_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            S_WB:    state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      alu_op    = 2'b00;
      alu_src   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      reg_write = 1'b0;
      wb_sel    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      halted    = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write = imem_valid;
            pc_write = imem_valid;
         end
         S_DECODE: begin
            if (opcode == OP_J) begin
               pc_write = 1'b1;
               pc_src   = 2'd2;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_SUB: alu_op = 2'b01;
               OP_AND: alu_op = 2'b10;
               OP_ADDI, OP_LW, OP_SW: alu_src = 1'b1;
               OP_BEQ: begin
                  alu_op   = 2'b01;
                  pc_src   = 2'd1;
                  pc_write = zero;
               end
               default: alu_op = 2'b00;
            endcase
         end
         S_MEM: begin
            alu_src = 1'b1;
            mem_rd  = (opcode == OP_LW);
            mem_wr  = (opcode == OP_SW);
         end
         S_WB: begin
            reg_write = 1'b1;
            wb_sel    = (opcode == OP_LW);
         end
         S_HALT:  halted = 1'b1;
         default: halted = 1'b0;
      endcase
      // FETCH strobes follow imem_valid, so hold everything low while in reset.
      if (!rst_n) begin
         ir_write = 1'b0;
         pc_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand-written
// timeout and asynchronous-reset sequences.
module tb_multicycle_control;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        imem_valid, zero, dmem_ready;
   logic [1:0]  alu_op, pc_src;
   logic        alu_src, ir_write, pc_write, reg_write, wb_sel;
   logic        mem_rd, mem_wr, halted, illegal, mem_timeout;

   multicycle_control #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_valid(imem_valid),
      .zero(zero), .dmem_ready(dmem_ready), .alu_op(alu_op), .alu_src(alu_src),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .wb_sel(wb_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .halted(halted), .illegal(illegal), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   logic [13:0] got;
   assign got = {alu_op, alu_src, ir_write, pc_write, pc_src, reg_write, wb_sel,
                 mem_rd, mem_wr, halted, illegal, mem_timeout};

   typedef struct {
      logic        r;
      logic [3:0]  op;
      logic        iv;
      logic        z;
      logic        dr;
      logic [13:0] ex;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   function automatic logic [13:0] x(input logic [1:0] aop, input logic src, irw, pcw,
                                     input logic [1:0] psrc, input logic rw, wbs, mrd,
                                     mwr, h, il, mt);
      return {aop, src, irw, pcw, psrc, rw, wbs, mrd, mwr, h, il, mt};
   endfunction

   task automatic check(input logic [13:0] ex, input string nm);
      tests++;
      if (got !== ex) begin
         fails++;
         $display("FAIL %s: got %b expected %b", nm, got, ex);
      end
   endtask

   task automatic apply(input logic r, input logic [3:0] op, input logic iv, z, dr,
                        input logic [13:0] ex, input string nm);
      rst_n = r; instr = {op, 28'h0ABCDEF}; imem_valid = iv; zero = z; dmem_ready = dr;
      @(negedge clk);
      check(ex, nm);
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [3:0] op, input logic iv, z, dr,
                      input logic [13:0] ex);
      vec_t v;
      v.r = r; v.op = op; v.iv = iv; v.z = z; v.dr = dr; v.ex = ex;
      vecs.push_back(v);
   endtask

   logic [13:0] NUL, FET, RW0, RW1, SRC1, RD, WR;

   initial begin
      NUL  = 14'h0;
      FET  = x(2'b00, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      RW0  = x(2'b00, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0);
      RW1  = x(2'b00, 0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0);
      SRC1 = x(2'b00, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
      RD   = x(2'b00, 1, 0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
      WR   = x(2'b00, 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0);

      // reset with imem_valid high: all outputs low
      add(0, 4'h0, 1, 0, 0, NUL);
      // ADD
      add(1, 4'h0, 1, 0, 0, FET);  add(1, 4'h1, 1, 0, 0, NUL);
      add(1, 4'h1, 1, 0, 0, NUL);  add(1, 4'h1, 1, 0, 0, RW0);
      // SUB with one fetch stall
      add(1, 4'h1, 0, 0, 0, NUL);  add(1, 4'h1, 1, 0, 0, FET);
      add(1, 4'h2, 1, 0, 0, NUL);
      add(1, 4'h2, 1, 0, 0, x(2'b01, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
      add(1, 4'h2, 1, 0, 0, RW0);
      // AND
      add(1, 4'h2, 1, 0, 0, FET);  add(1, 4'h3, 1, 0, 0, NUL);
      add(1, 4'h3, 1, 0, 0, x(2'b10, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0));
      add(1, 4'h3, 1, 0, 0, RW0);
      // ADDI
      add(1, 4'h3, 1, 0, 0, FET);  add(1, 4'h4, 1, 0, 0, NUL);
      add(1, 4'h4, 1, 0, 0, SRC1); add(1, 4'h4, 1, 0, 0, RW0);
      // LW: 3 wait cycles, ready on the cycle the counter would hit TIMEOUT
      add(1, 4'h4, 1, 0, 0, FET);  add(1, 4'h6, 1, 0, 0, NUL);
      add(1, 4'h6, 1, 0, 0, SRC1);
      add(1, 4'h6, 1, 0, 0, RD);   add(1, 4'h6, 1, 0, 0, RD);
      add(1, 4'h6, 1, 0, 0, RD);   add(1, 4'h6, 1, 0, 1, RD);
      add(1, 4'h6, 1, 0, 0, RW1);
      // BEQ taken / not taken
      add(1, 4'h6, 1, 1, 0, FET);  add(1, 4'h6, 1, 1, 0, NUL);
      add(1, 4'h6, 1, 1, 0, x(2'b01, 0, 0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0));
      add(1, 4'h6, 1, 0, 0, FET);  add(1, 4'h7, 1, 0, 0, NUL);
      add(1, 4'h7, 1, 0, 0, x(2'b01, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0));
      // J
      add(1, 4'h7, 1, 0, 0, FET);
      add(1, 4'h5, 1, 0, 0, x(2'b00, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0));
      // SW, immediate ready
      add(1, 4'h5, 1, 0, 0, FET);  add(1, 4'h9, 1, 0, 0, NUL);
      add(1, 4'h9, 1, 0, 0, SRC1); add(1, 4'h9, 1, 0, 1, WR);
      // illegal opcode 9
      add(1, 4'h9, 1, 0, 0, FET);  add(1, 4'h0, 1, 0, 0, NUL);
      add(1, 4'h0, 1, 0, 0, x(2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
      add(1, 4'h0, 1, 1, 1, x(2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0));
      // reset, then HLT
      add(0, 4'hF, 1, 0, 0, NUL);
      add(1, 4'hF, 1, 0, 0, FET);  add(1, 4'h0, 1, 0, 0, NUL);
      add(1, 4'h0, 1, 0, 0, x(2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
      add(0, 4'h0, 0, 0, 0, NUL);

      rst_n = 0; instr = 32'h0; imem_valid = 0; zero = 0; dmem_ready = 0;
      #1;
      foreach (vecs[i])
         apply(vecs[i].r, vecs[i].op, vecs[i].iv, vecs[i].z, vecs[i].dr, vecs[i].ex,
               $sformatf("vec%0d", i));

      // SW with dmem_ready never asserted: TIMEOUT cycles of mem_wr, then halt
      apply(1, 4'h5, 1, 0, 0, FET, "sw_to_fetch");
      apply(1, 4'h0, 1, 0, 0, NUL, "sw_to_decode");
      apply(1, 4'h0, 1, 0, 0, SRC1, "sw_to_exec");
      for (int k = 0; k < TO; k++)
         apply(1, 4'h0, 1, 0, 0, WR, $sformatf("sw_to_mem%0d", k));
      apply(1, 4'h0, 1, 0, 0, x(2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1), "sw_to_halt");
      apply(1, 4'h0, 1, 1, 1, x(2'b00, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1), "sw_to_hold");

      // async reset in the middle of an LW memory wait
      apply(0, 4'h0, 0, 0, 0, NUL, "ar_reset");
      apply(1, 4'h4, 1, 0, 0, FET, "ar_fetch");
      apply(1, 4'h0, 0, 0, 0, NUL, "ar_decode");
      apply(1, 4'h0, 0, 0, 0, SRC1, "ar_exec");
      @(negedge clk);
      check(RD, "ar_mem");
      #1 rst_n = 0;
      #1 check(NUL, "ar_async_drop");
      @(posedge clk);
      #1 rst_n = 1; imem_valid = 1;
      @(negedge clk);
      check(FET, "ar_after_release");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
